// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, issues word fetches under a
// credit limit and buffers returned instructions in an in-order FIFO for decode.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_aq_rd;
  logic [PW-1:0] r_aq_wr;
  logic [31:0]   r_instr [DEPTH];
  logic [63:0]   r_pc    [DEPTH];
  logic [63:0]   r_aq    [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_issue;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_target;

  // Issue is gated by reset so the request port stays quiet while held in reset.
  always_comb begin
    w_occ    = {1'b0, r_count} + {1'b0, r_inflight};
    w_issue  = reset && !redirect_valid && !halt && (w_occ < (CW+1)'(DEPTH));
    w_acc    = w_issue && imem_req_ready;
    w_push   = imem_rsp_valid && !redirect_valid && (r_drop == '0);
    w_pop    = out_valid && out_ready && !redirect_valid;
    w_target = redirect_pc & ~64'd3;
  end

  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_fetch_pc;
  assign out_valid      = (r_count != '0);
  assign out_instr      = r_instr[r_rd];
  assign out_pc         = r_pc[r_rd];
  assign out_pc4        = r_pc[r_rd] + 64'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_aq_rd    <= '0;
      r_aq_wr    <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_acc) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) r_aq_rd <= r_aq_rd + PW'(1);
      if (w_acc)          r_aq_wr <= r_aq_wr + PW'(1);
      if (w_push)         r_wr    <= r_wr + PW'(1);
      if (redirect_valid) begin
        // Everything still outstanding, minus a response landing now, is stale.
        r_fetch_pc <= w_target;
        r_count    <= '0;
        r_rd       <= r_wr;
        r_drop     <= r_inflight - CW'(imem_rsp_valid);
      end else begin
        if (w_acc) r_fetch_pc <= r_fetch_pc + 64'd4;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_pop) r_rd <= r_rd + PW'(1);
        if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_aq[i]    <= '0;
      end
    end else begin
      if (w_push) begin
        r_instr[r_wr] <= imem_rsp_data;
        r_pc[r_wr]    <= r_aq[r_aq_rd];
      end
      if (w_acc) r_aq[r_aq_wr] <= r_fetch_pc;
    end
  end

endmodule

// File: doc/tinker_fetch_queue.md
# tinker_fetch_queue

Instruction prefetch stage for the Tinker pipeline. It sits directly upstream of the IF/ID register. It owns the fetch PC, issues word fetches to the instruction memory port, and buffers returned instructions in a small in-order FIFO. It presents them to decode through a valid/ready handshake. A taken branch resolved in EX redirects it, which flushes all buffered and in-flight instructions.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight requests combined; power of two, ≥2
- RESET_PC, 64'h2000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  byte address of requested word
- imem_rsp_valid  in  1  in-order response valid; responses cannot be backpressured
- imem_rsp_data  in  32  little-endian instruction word
- redirect_valid  in  1  taken branch from EX, single-cycle pulse
- redirect_pc  in  64  branch target
- halt  in  1  core halted; stop issuing new requests
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts; low while the core stalls on load-use
- out_instr  out  32  instruction at FIFO head
- out_pc  out  64  address of out_instr
- out_pc4  out  64  out_pc + 4

## Operation
- State: fetch_pc (64), FIFO of {instr, pc} with DEPTH entries, count (0..DEPTH), inflight (0..DEPTH), drop (0..DEPTH).
- Issue: imem_req_valid = !redirect_valid && !halt && (count + inflight < DEPTH). imem_req_addr = fetch_pc.
- On accept (valid && ready): fetch_pc += 4, modulo 2^64 (wraps to 0); inflight += 1. Each request records its address in a DEPTH-deep in-order address queue, pushed on accept and popped on response.
- Response with drop > 0: discard it; drop −= 1; inflight −= 1.
- Response with drop == 0: push {imem_rsp_data, recorded addr} to the FIFO; inflight −= 1.
- The credit rule guarantees the FIFO is never full when a response arrives. An overflow push is a design error, and the bench asserts that it never occurs.
- Pop: out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid = 1 at edge):
  - Empty the FIFO (count ← 0).
  - fetch_pc ← {redirect_pc[63:2], 2'b00}; the low two bits are ignored.
  - drop ← inflight − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded directly.
  - No request is issued in the redirect cycle.
  - Any pop handshake in the same cycle still completes for decode, but the FIFO is emptied regardless.
- Redirect has priority over push, pop and issue.
- Back-to-back redirects: each recomputes drop from the current inflight, and the last target wins.
- Halt: issuing is suppressed only. In-flight responses still land, and the FIFO still drains. Deasserting halt resumes fetching at fetch_pc.

## Timing
- During reset: imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0, out_pc4 = 4, fetch_pc = RESET_PC, count = inflight = drop = 0.
- First cycle after reset release: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Fetch latency: a response at edge t is at the FIFO head with out_valid = 1 in cycle t+1 when the FIFO was empty. There is no combinational response-to-output bypass.
- out_* are driven from the FIFO head registers and are stable while out_valid && !out_ready.
- Redirect at edge t:
  - out_valid = 0 from t+1 until the first post-redirect response is pushed.
  - imem_req_valid = 1 with addr = target in cycle t+1, if not halted.
- Throughput: one instruction per cycle when memory returns one response per cycle and out_ready = 1.
- Reset asserted mid-operation clears all state immediately (asynchronously). Responses to requests issued before reset are not tracked; memory is reset alongside this block.

## Test plan
- Reset release, 1-cycle memory latency, out_ready = 1 → requests to 0x2000, 0x2004, 0x2008…; out_pc follows the same sequence one cycle after each response; out_pc4 = out_pc + 4.
- out_ready = 0 for 10 cycles with DEPTH = 4 → at most 4 requests are accepted, and count + inflight never exceeds 4. Raising out_ready drains 0x2000..0x200C in order, and no response is lost.
- 3-cycle memory latency with 3 requests in flight, then redirect to 0x3003 → all 3 old responses are discarded; the next out_pc is 0x3000, and the next request address is 0x3000.
- Redirect in the same cycle as a response arrives and out_ready = 1 → that response is dropped; drop equals inflight − 1; no stale pc appears at the output.
- halt = 1 with 2 requests in flight → no new imem_req_valid; both instructions still appear on out_*. Deasserting halt resumes at the next sequential pc.
- Assert reset mid-stream with the FIFO full → outputs reach reset values within the same cycle, without waiting for a clock edge. After release, fetching restarts at 0x2000.
